wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter WbSize, default 4, meaning width of the write-back control bundle i_WB.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_valid  input  1  MEM/WB buffer holds a live instruction this cycle.
REQ-005 SHALL have port i_WB  input  WbSize  control: [0] RegWrite, [1] MemToReg, [2] Wide (32-bit pair write), [3] OutEn.
REQ-006 SHALL have port i_MemData  input  32  memory read data from the MEM/WB buffer.
REQ-007 SHALL have port i_alu  input  16  ALU result from the MEM/WB buffer.
REQ-008 SHALL have port i_Rdst  input  3  destination register index.
REQ-009 SHALL have port o_rf_we  output  1  register-file write enable.
REQ-010 SHALL have port o_rf_addr  output  3  register-file write address.
REQ-011 SHALL have port o_rf_data  output  16  register-file write data.
REQ-012 SHALL have port o_out_port  output  16  output-port register.
REQ-013 SHALL have port o_stall  output  1  hold request; drives MEM/WB buffer enable low while high.
REQ-014 SHALL have port o_retired  output  16  count of completed instructions.

Function
REQ-015 SHALL be a two-state machine: IDLE, HIGH; all outputs registered, one-cycle latency from the capturing edge.
REQ-016 SHALL, in IDLE with i_valid=1 and RegWrite=1 and Wide=0, at the edge set o_rf_we=1, o_rf_addr=i_Rdst, o_rf_data=(MemToReg ? i_MemData[15:0] : i_alu), stay IDLE.
REQ-017 SHALL, in IDLE with i_valid=1, RegWrite=1, Wide=1, at the edge set o_rf_we=1, o_rf_addr=i_Rdst, o_rf_data=i_MemData[15:0], latch i_MemData[31:16] and i_Rdst internally, move to HIGH.
REQ-018 SHALL, in HIGH, at the next edge set o_rf_we=1, o_rf_addr=(latched Rdst+1) mod 8 (7 wraps to 0), o_rf_data=latched high half, return to IDLE; inputs ignored in HIGH.
REQ-019 SHALL drive o_stall=1 exactly while state is HIGH (registered), so the negedge-updated MEM/WB buffer holds for one extra cycle.
REQ-020 SHALL, when i_valid=0 or RegWrite=0 in IDLE, set o_rf_we=0 at the edge; o_rf_addr/o_rf_data hold prior values; Wide ignored when RegWrite=0.
REQ-021 SHALL, in IDLE with i_valid=1 and OutEn=1, load o_out_port with the 16-bit value selected as in REQ-016 (low half for Wide); otherwise o_out_port holds.
REQ-022 SHALL increment o_retired by 1 per completed instruction: each IDLE edge with i_valid=1 and not entering HIGH, and each HIGH->IDLE edge; Wide counts once; wraps 0xFFFF->0x0000.
REQ-023 SHALL treat i_valid=1 with RegWrite=0 and OutEn=0 as a completed no-op (counted, no write).

Reset
REQ-024 SHALL, while rst=0, force state=IDLE, o_rf_we=0, o_rf_addr=0, o_rf_data=0, o_out_port=0, o_stall=0, o_retired=0, latched high half and Rdst=0, independent of clk.
REQ-025 SHALL, on reset asserted in HIGH, discard the pending high-half write (no write after release, not counted).
REQ-026 SHALL resume normal operation on the first rising edge after rst deasserts.

Verification
REQ-027 SHALL cover: IDLE, i_valid=1, i_WB=0011, i_MemData=0x1234ABCD, i_Rdst=2 -> next cycle we=1, addr=2, data=0xABCD, stall=0, retired=1.
REQ-028 SHALL cover: i_WB=0111, i_MemData=0xBEEF5555, i_Rdst=7 -> cycle1 addr=7 data=0x5555 stall=1; cycle2 addr=0 data=0xBEEF stall=0; retired +1.
REQ-029 SHALL cover: i_WB=1001, i_alu=0x00F0, i_Rdst=4 -> we=1 addr=4 data=0x00F0, o_out_port=0x00F0; following i_WB=0000 valid -> we=0, out_port holds 0x00F0.
REQ-030 SHALL cover: Wide write started, rst pulsed low during HIGH -> all outputs 0 immediately, no high-half write after release, retired=0.
REQ-031 SHALL cover: preload retired=0xFFFF via 65535 valid no-ops, one more valid instruction -> retired=0x0000.

Source files
------------

// File: rtl/wb_stage_if.sv
// Write-back stage bundle: MEM/WB buffer fields in, register-file/output-port results out.
// Transfer rule: an instruction is taken on any rising edge where i_valid=1 and o_stall=0; while o_stall=1 the buffer must hold.
interface wb_stage_if #(parameter int WbSize = 4);
  logic              i_valid;
  logic [WbSize-1:0] i_WB;
  logic [31:0]       i_MemData;
  logic [15:0]       i_alu;
  logic [2:0]        i_Rdst;
  logic              o_rf_we;
  logic [2:0]        o_rf_addr;
  logic [15:0]       o_rf_data;
  logic [15:0]       o_out_port;
  logic              o_stall;
  logic [15:0]       o_retired;
  logic              dbg_state;

  modport master (
    output i_valid, i_WB, i_MemData, i_alu, i_Rdst,
    input  o_rf_we, o_rf_addr, o_rf_data, o_out_port, o_stall, o_retired, dbg_state
  );

  modport slave (
    input  i_valid, i_WB, i_MemData, i_alu, i_Rdst,
    output o_rf_we, o_rf_addr, o_rf_data, o_out_port, o_stall, o_retired, dbg_state
  );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: single 16-bit register-file writes, or a two-cycle 32-bit pair write
// (low half to Rdst, then high half to Rdst+1) with a registered stall during the second cycle.
module wb_stage #(
  parameter int WbSize = 4
) (
  input  logic         clk,
  input  logic         rst,
  wb_stage_if.slave    bus
);
  typedef enum logic {IDLE = 1'b0, HIGH = 1'b1} state_t;

  state_t      state_q, state_n;
  logic        we_q, we_n;
  logic [2:0]  addr_q, addr_n;
  logic [15:0] data_q, data_n;
  logic [15:0] out_q, out_n;
  logic        stall_q, stall_n;
  logic [15:0] retired_q, retired_n;
  logic [15:0] hi_data_q, hi_data_n;
  logic [2:0]  hi_rdst_q, hi_rdst_n;

  logic [WbSize-1:0] wb;
  logic              reg_write, mem_to_reg, wide_wr, out_en;
  logic [15:0]       sel_data, wr_data;

  assign wb         = bus.i_WB;
  assign reg_write  = wb[0];
  assign mem_to_reg = wb[1];
  assign out_en     = wb[3];
  // Wide only has meaning for an actual register write.
  assign wide_wr    = wb[0] & wb[2];
  assign sel_data   = mem_to_reg ? bus.i_MemData[15:0] : bus.i_alu;
  assign wr_data    = wide_wr ? bus.i_MemData[15:0] : sel_data;

  always_comb begin
    state_n   = state_q;
    we_n      = 1'b0;
    addr_n    = addr_q;
    data_n    = data_q;
    out_n     = out_q;
    stall_n   = 1'b0;
    retired_n = retired_q;
    hi_data_n = hi_data_q;
    hi_rdst_n = hi_rdst_q;
    case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          if (reg_write) begin
            we_n   = 1'b1;
            addr_n = bus.i_Rdst;
            data_n = wr_data;
          end
          if (out_en) out_n = wr_data;
          if (wide_wr) begin
            state_n   = HIGH;
            stall_n   = 1'b1;
            hi_data_n = bus.i_MemData[31:16];
            hi_rdst_n = bus.i_Rdst;
          end else begin
            retired_n = retired_q + 16'd1;
          end
        end
      end
      HIGH: begin
        // Inputs are ignored here; the buffer is being held by the stall.
        we_n      = 1'b1;
        addr_n    = hi_rdst_q + 3'd1;
        data_n    = hi_data_q;
        state_n   = IDLE;
        retired_n = retired_q + 16'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= 3'd0;
      data_q    <= 16'd0;
      out_q     <= 16'd0;
      stall_q   <= 1'b0;
      retired_q <= 16'd0;
      hi_data_q <= 16'd0;
      hi_rdst_q <= 3'd0;
    end else begin
      state_q   <= state_n;
      we_q      <= we_n;
      addr_q    <= addr_n;
      data_q    <= data_n;
      out_q     <= out_n;
      stall_q   <= stall_n;
      retired_q <= retired_n;
      hi_data_q <= hi_data_n;
      hi_rdst_q <= hi_rdst_n;
    end
  end

  assign bus.o_rf_we    = we_q;
  assign bus.o_rf_addr  = addr_q;
  assign bus.o_rf_data  = data_q;
  assign bus.o_out_port = out_q;
  assign bus.o_stall    = stall_q;
  assign bus.o_retired  = retired_q;
  assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: narrow/wide writes, output port, reset during HIGH, retired-count wrap.
module tb_wb_stage;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  wb_stage_if #(.WbSize(4)) bus ();

  wb_stage #(.WbSize(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] wbv, input logic [31:0] mem,
                       input logic [15:0] alu, input logic [2:0] rd);
    bus.i_valid   = v;
    bus.i_WB      = wbv;
    bus.i_MemData = mem;
    bus.i_alu     = alu;
    bus.i_Rdst    = rd;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    drive(1'b0, 4'b0000, 32'h0, 16'h0, 3'd0);
    #3;
    check("rst_we",      {31'd0, bus.o_rf_we},   32'd0);
    check("rst_addr",    {29'd0, bus.o_rf_addr}, 32'd0);
    check("rst_data",    {16'd0, bus.o_rf_data}, 32'd0);
    check("rst_out",     {16'd0, bus.o_out_port}, 32'd0);
    check("rst_stall",   {31'd0, bus.o_stall},   32'd0);
    check("rst_retired", {16'd0, bus.o_retired}, 32'd0);

    // Narrow MemToReg write
    #19;
    rst = 1'b1;
    drive(1'b1, 4'b0011, 32'h1234ABCD, 16'h1111, 3'd2);
    step();
    check("a_we",      {31'd0, bus.o_rf_we},   32'd1);
    check("a_addr",    {29'd0, bus.o_rf_addr}, 32'd2);
    check("a_data",    {16'd0, bus.o_rf_data}, 32'h0000ABCD);
    check("a_stall",   {31'd0, bus.o_stall},   32'd0);
    check("a_retired", {16'd0, bus.o_retired}, 32'd1);

    // Wide write to r7, high half wraps to r0; inputs during HIGH must be ignored
    drive(1'b1, 4'b0111, 32'hBEEF5555, 16'h2222, 3'd7);
    step();
    check("w1_we",      {31'd0, bus.o_rf_we},   32'd1);
    check("w1_addr",    {29'd0, bus.o_rf_addr}, 32'd7);
    check("w1_data",    {16'd0, bus.o_rf_data}, 32'h00005555);
    check("w1_stall",   {31'd0, bus.o_stall},   32'd1);
    check("w1_state",   {31'd0, bus.dbg_state}, 32'd1);
    check("w1_retired", {16'd0, bus.o_retired}, 32'd1);
    drive(1'b1, 4'b1001, 32'h0, 16'h9999, 3'd3);
    step();
    check("w2_we",      {31'd0, bus.o_rf_we},   32'd1);
    check("w2_addr",    {29'd0, bus.o_rf_addr}, 32'd0);
    check("w2_data",    {16'd0, bus.o_rf_data}, 32'h0000BEEF);
    check("w2_stall",   {31'd0, bus.o_stall},   32'd0);
    check("w2_out",     {16'd0, bus.o_out_port}, 32'd0);
    check("w2_retired", {16'd0, bus.o_retired}, 32'd2);

    // Bubble: no write, address/data hold
    drive(1'b0, 4'b0011, 32'hFFFFFFFF, 16'hFFFF, 3'd6);
    step();
    check("b_we",      {31'd0, bus.o_rf_we},   32'd0);
    check("b_addr",    {29'd0, bus.o_rf_addr}, 32'd0);
    check("b_data",    {16'd0, bus.o_rf_data}, 32'h0000BEEF);
    check("b_retired", {16'd0, bus.o_retired}, 32'd2);

    // ALU write with OutEn, then a valid no-op
    drive(1'b1, 4'b1001, 32'h0, 16'h00F0, 3'd4);
    step();
    check("o_we",      {31'd0, bus.o_rf_we},    32'd1);
    check("o_addr",    {29'd0, bus.o_rf_addr},  32'd4);
    check("o_data",    {16'd0, bus.o_rf_data},  32'h000000F0);
    check("o_out",     {16'd0, bus.o_out_port}, 32'h000000F0);
    check("o_retired", {16'd0, bus.o_retired},  32'd3);
    drive(1'b1, 4'b0000, 32'h5678, 16'h1234, 3'd1);
    step();
    check("n_we",      {31'd0, bus.o_rf_we},    32'd0);
    check("n_out",     {16'd0, bus.o_out_port}, 32'h000000F0);
    check("n_addr",    {29'd0, bus.o_rf_addr},  32'd4);
    check("n_retired", {16'd0, bus.o_retired},  32'd4);

    // Wide without RegWrite is ignored; OutEn takes MemToReg-selected value
    drive(1'b1, 4'b1110, 32'hAAAA5A5A, 16'h0707, 3'd5);
    step();
    check("x_we",      {31'd0, bus.o_rf_we},    32'd0);
    check("x_stall",   {31'd0, bus.o_stall},    32'd0);
    check("x_out",     {16'd0, bus.o_out_port}, 32'h00005A5A);
    check("x_retired", {16'd0, bus.o_retired},  32'd5);

    // Reset pulsed during HIGH drops the pending high half
    drive(1'b1, 4'b0111, 32'hCAFEF00D, 16'h0, 3'd5);
    step();
    check("r1_stall",   {31'd0, bus.o_stall},   32'd1);
    check("r1_data",    {16'd0, bus.o_rf_data}, 32'h0000F00D);
    check("r1_retired", {16'd0, bus.o_retired}, 32'd5);
    drive(1'b0, 4'b0000, 32'h0, 16'h0, 3'd0);
    #2;
    rst = 1'b0;
    #1;
    check("r2_we",      {31'd0, bus.o_rf_we},    32'd0);
    check("r2_addr",    {29'd0, bus.o_rf_addr},  32'd0);
    check("r2_data",    {16'd0, bus.o_rf_data},  32'd0);
    check("r2_out",     {16'd0, bus.o_out_port}, 32'd0);
    check("r2_stall",   {31'd0, bus.o_stall},    32'd0);
    check("r2_retired", {16'd0, bus.o_retired},  32'd0);
    @(negedge clk);
    rst = 1'b1;
    step();
    check("r3_we",      {31'd0, bus.o_rf_we},   32'd0);
    check("r3_addr",    {29'd0, bus.o_rf_addr}, 32'd0);
    check("r3_data",    {16'd0, bus.o_rf_data}, 32'd0);
    check("r3_retired", {16'd0, bus.o_retired}, 32'd0);
    step();
    check("r4_we",      {31'd0, bus.o_rf_we},   32'd0);

    // Retired counter wrap
    drive(1'b1, 4'b0000, 32'h0, 16'h0, 3'd0);
    repeat (65535) @(posedge clk);
    #1;
    check("c_ffff", {16'd0, bus.o_retired}, 32'h0000FFFF);
    step();
    check("c_wrap", {16'd0, bus.o_retired}, 32'h00000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
